// File: rtl/usb_data_buffer_if.sv
// Bus bundle between the USB endpoint byte FIFO and its two users: the
// AHB-lite slave and the USB RX/TX packet engines.
//
// Handshake: there is no ready. Each strobe is a one-cycle request that is
// sampled at the rising clock edge.
// - Pushes (store_tx_data, store_rx_packet_data) are dropped if the buffer is
//   full and no pop happens in the same cycle. overflow records the drop.
// - Pops (get_rx_data, get_tx_packet_data) are dropped if the buffer is
//   empty. underflow records the drop.
// - The head byte is show-ahead: the popper takes rx_data or tx_packet_data
//   in the same cycle that it raises its pop strobe.
interface usb_data_buffer_if #(
    parameter int ADDR_BITS = 6
);
    logic                 clear;
    logic                 store_tx_data;
    logic [7:0]           tx_data;
    logic                 get_rx_data;
    logic [7:0]           rx_data;
    logic                 store_rx_packet_data;
    logic [7:0]           rx_packet_data;
    logic                 get_tx_packet_data;
    logic [7:0]           tx_packet_data;
    logic [ADDR_BITS:0]   buffer_occupancy;
    logic                 overflow;
    logic                 underflow;

    // Buffer side
    modport slave (
        input  clear, store_tx_data, tx_data, get_rx_data,
        input  store_rx_packet_data, rx_packet_data, get_tx_packet_data,
        output rx_data, tx_packet_data, buffer_occupancy, overflow, underflow
    );

    // Requester side (AHB slave plus USB engines, or a testbench)
    modport master (
        output clear, store_tx_data, tx_data, get_rx_data,
        output store_rx_packet_data, rx_packet_data, get_tx_packet_data,
        input  rx_data, tx_packet_data, buffer_occupancy, overflow, underflow
    );
endinterface

// File: rtl/usb_data_buffer.sv
// Shared byte FIFO for the USB 1.1 endpoint. The buffer is built from a
// write pointer and a read pointer. Each pointer has one extra wrap bit, so
// the occupancy is the plain modulo difference of the two pointers. The
// head byte is show-ahead and reads 8'h00 whenever the buffer is empty.
module usb_data_buffer #(
    parameter int DEPTH     = 64,
    parameter int ADDR_BITS = 6
) (
    input  logic              clk,
    input  logic              n_rst,
    usb_data_buffer_if.slave  bus
);
    localparam logic [ADDR_BITS:0] PTR_ONE    = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS+1)'(DEPTH);

    logic [ADDR_BITS:0] wptr_q, wptr_d;
    logic [ADDR_BITS:0] rptr_q, rptr_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic [7:0]         mem_q [DEPTH];

    logic [ADDR_BITS:0] occupancy;
    logic               full;
    logic               empty;
    logic               push_req;
    logic               pop_req;
    logic               do_push;
    logic               do_pop;
    logic [7:0]         wr_byte;

    // Status and request decode. A full buffer is never empty, so a pop made
    // while full always executes. That pop frees the slot the push needs.
    always_comb begin
        occupancy = wptr_q - rptr_q;
        full      = (occupancy == FULL_COUNT);
        empty     = (occupancy == '0);
        push_req  = bus.store_tx_data | bus.store_rx_packet_data;
        pop_req   = bus.get_rx_data | bus.get_tx_packet_data;
        // If both sides push in the same cycle, the AHB byte wins.
        wr_byte   = bus.store_tx_data ? bus.tx_data : bus.rx_packet_data;
        do_pop    = pop_req && !empty && !bus.clear;
        do_push   = push_req && (!full || pop_req) && !bus.clear;
    end

    // Next pointer and flag values. clear overrides every transfer.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.clear) begin
            wptr_d      = '0;
            rptr_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (do_push) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            if (push_req && full && !pop_req) begin
                overflow_d = 1'b1;
            end
            if (pop_req && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Pointer and sticky flag registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Byte storage. The contents have no reset value and only the pointers
    // decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[ADDR_BITS-1:0]] <= wr_byte;
        end
    end

    // Output drive. Both head views carry the same byte.
    always_comb begin
        bus.rx_data          = empty ? 8'h00 : mem_q[rptr_q[ADDR_BITS-1:0]];
        bus.tx_packet_data   = bus.rx_data;
        bus.buffer_occupancy = occupancy;
        bus.overflow         = overflow_q;
        bus.underflow        = underflow_q;
    end
endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench for usb_data_buffer. A queue-based model follows every
// clock edge and every reset. On each falling clock edge the bench compares
// all DUT outputs against that model. Literal checks at key points make sure
// the model itself holds the right values.
module tb_usb_data_buffer;
    localparam int DEPTH     = 64;
    localparam int ADDR_BITS = 6;

    logic clk;
    logic n_rst;

    usb_data_buffer_if #(.ADDR_BITS(ADDR_BITS)) bus ();

    usb_data_buffer #(.DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] model_q [$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (bus.clear) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            automatic bit   push = bus.store_tx_data || bus.store_rx_packet_data;
            automatic bit   pop  = bus.get_rx_data || bus.get_tx_packet_data;
            automatic logic [7:0] b = bus.store_tx_data ? bus.tx_data : bus.rx_packet_data;
            automatic int   sz   = model_q.size();
            automatic bit   popped = pop && (sz > 0);
            automatic bit   pushed = push && ((sz < DEPTH) || popped);
            if (pop && sz == 0) m_unf = 1'b1;
            if (push && sz == DEPTH && !pop) m_ovf = 1'b1;
            if (popped) void'(model_q.pop_front());
            if (pushed) model_q.push_back(b);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        automatic int exp_head = (model_q.size() > 0) ? int'(model_q[0]) : 0;
        check("rx_data",          int'(bus.rx_data),          exp_head);
        check("tx_packet_data",   int'(bus.tx_packet_data),   exp_head);
        check("buffer_occupancy", int'(bus.buffer_occupancy), model_q.size());
        check("overflow",         int'(bus.overflow),         int'(m_ovf));
        check("underflow",        int'(bus.underflow),        int'(m_unf));
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic stx, input logic [7:0] txd,
                        input logic srx, input logic [7:0] rxd,
                        input logic grx, input logic gtx, input logic clr);
        bus.store_tx_data        = stx;
        bus.tx_data              = txd;
        bus.store_rx_packet_data = srx;
        bus.rx_packet_data       = rxd;
        bus.get_rx_data          = grx;
        bus.get_tx_packet_data   = gtx;
        bus.clear                = clr;
        @(posedge clk);
        #1;
        bus.store_tx_data        = 1'b0;
        bus.store_rx_packet_data = 1'b0;
        bus.get_rx_data          = 1'b0;
        bus.get_tx_packet_data   = 1'b0;
        bus.clear                = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b);
        step(1'b1, b, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_rx();
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_rst                    = 1'b0;
        bus.clear                = 1'b0;
        bus.store_tx_data        = 1'b0;
        bus.tx_data              = 8'h00;
        bus.get_rx_data          = 1'b0;
        bus.store_rx_packet_data = 1'b0;
        bus.rx_packet_data       = 8'h00;
        bus.get_tx_packet_data   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_occ",  int'(bus.buffer_occupancy), 0);
        check("reset_data", int'(bus.rx_data), 0);
        check("reset_ovf",  int'(bus.overflow), 0);
        check("reset_unf",  int'(bus.underflow), 0);
        n_rst = 1'b1;
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Three bytes pushed from the AHB side and popped back in order.
        push_tx(8'hA1);
        push_tx(8'hB2);
        push_tx(8'hC3);
        check("t1_occ",  int'(bus.buffer_occupancy), 3);
        check("t1_head", int'(bus.tx_packet_data), 8'hA1);
        check("t1_pop0", int'(bus.rx_data), 8'hA1);
        pop_rx();
        check("t1_pop1", int'(bus.rx_data), 8'hB2);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("t1_pop2", int'(bus.tx_packet_data), 8'hC3);
        pop_rx();
        check("t1_empty_occ",  int'(bus.buffer_occupancy), 0);
        check("t1_empty_data", int'(bus.rx_data), 0);

        // Fill to capacity, then one more push must be dropped as overflow.
        for (int i = 0; i < DEPTH; i++) push_tx(8'(i));
        check("t2_full_occ", int'(bus.buffer_occupancy), DEPTH);
        check("t2_no_ovf",   int'(bus.overflow), 0);
        push_tx(8'hFF);
        check("t2_ovf",      int'(bus.overflow), 1);
        check("t2_occ",      int'(bus.buffer_occupancy), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            check("t2_order", int'(bus.rx_data), i);
            pop_rx();
        end
        check("t2_drained", int'(bus.buffer_occupancy), 0);
        check("t2_sticky",  int'(bus.overflow), 1);
        do_clear();

        // Move both pointers away from zero, then stream enough bytes that
        // the pointers wrap.
        for (int i = 0; i < 40; i++) push_tx(8'(i + 8'h40));
        for (int i = 0; i < 40; i++) pop_rx();
        push_tx(8'h00);
        for (int i = 1; i < 100; i++) begin
            check("t3_order", int'(bus.rx_data), i - 1);
            step(1'b1, 8'(i), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check("t3_occ_max", int'(bus.buffer_occupancy <= 40), 1);
        end
        check("t3_last", int'(bus.rx_data), 99);
        pop_rx();
        check("t3_ovf", int'(bus.overflow), 0);
        check("t3_unf", int'(bus.underflow), 0);

        // A clear wins over a push and a pop made in the same cycle.
        for (int i = 0; i < 10; i++) push_tx(8'(i + 1));
        step(1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("t4_occ",  int'(bus.buffer_occupancy), 0);
        check("t4_data", int'(bus.rx_data), 0);
        check("t4_ovf",  int'(bus.overflow), 0);

        // Pop from an empty buffer, then push from both sides at once.
        pop_rx();
        check("t5_unf", int'(bus.underflow), 1);
        check("t5_occ", int'(bus.buffer_occupancy), 0);
        step(1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        check("t5_occ1", int'(bus.buffer_occupancy), 1);
        check("t5_head", int'(bus.rx_data), 8'h11);
        check("t5_no_ovf", int'(bus.overflow), 0);
        // Push and pop together on an empty buffer: only the push executes.
        pop_rx();
        step(1'b0, 8'h00, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        check("t5_ep_occ",  int'(bus.buffer_occupancy), 1);
        check("t5_ep_head", int'(bus.rx_data), 8'h77);
        do_clear();

        // Asynchronous reset in the middle of a cycle
        for (int i = 0; i < 5; i++) push_tx(8'(8'hC0 + i));
        check("t6_occ5", int'(bus.buffer_occupancy), 5);
        #2;
        n_rst = 1'b0;
        #1;
        check("t6_async_occ",  int'(bus.buffer_occupancy), 0);
        check("t6_async_data", int'(bus.rx_data), 0);
        check("t6_async_ovf",  int'(bus.overflow), 0);
        check("t6_async_unf",  int'(bus.underflow), 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Random traffic with phases that push the buffer toward full and
        // toward empty in turn
        for (int i = 0; i < 3000; i++) begin
            automatic int phase = (i / 150) % 3;
            automatic int push_pct = (phase == 0) ? 80 : (phase == 1) ? 20 : 50;
            automatic int pop_pct  = (phase == 0) ? 20 : (phase == 1) ? 80 : 50;
            automatic logic stx = ($urandom_range(99) < push_pct) && ($urandom_range(1) == 1);
            automatic logic srx = ($urandom_range(99) < push_pct) && !stx ? 1'b1 :
                                  ($urandom_range(9) == 0);
            automatic logic grx = ($urandom_range(99) < pop_pct) && ($urandom_range(1) == 1);
            automatic logic gtx = ($urandom_range(99) < pop_pct) && !grx ? 1'b1 :
                                  ($urandom_range(9) == 0);
            automatic logic clr = ($urandom_range(199) == 0);
            step(stx, 8'($urandom_range(255)), srx, 8'($urandom_range(255)), grx, gtx, clr);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
